// File: rtl/tile_seq_controller.sv
// Tile sequencer for a weight-stationary systolic array with double-buffered weights.
// A weight FSM prefetches the next tile into the shadow buffer while the IF FSM streams and drains the current tile.
module tile_seq_controller #(
  parameter int ARRAY_DIM  = 4,
  parameter int TILE_CNT_W = 8,
  parameter int IF_LEN_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TILE_CNT_W-1:0] num_tiles,
  input  logic [IF_LEN_W-1:0]   if_len,
  input  logic                  stall,
  output logic                  w_read,
  output logic                  if_read,
  output logic                  clr_w,
  output logic                  clr_if,
  output logic                  switch,
  output logic [TILE_CNT_W-1:0] tile_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int DRAIN = 2*ARRAY_DIM - 1;
  localparam int WC_W  = $clog2(ARRAY_DIM + 1);
  localparam int DC_W  = $clog2(DRAIN + 1);

  typedef enum logic [1:0] {W_IDLE, W_CLR, W_LOAD, W_READY} w_state_t;
  typedef enum logic [1:0] {IF_IDLE, IF_RUN, IF_DRAIN} if_state_t;

  w_state_t              r_w_state;
  if_state_t             r_if_state;
  logic [WC_W-1:0]       r_w_cnt;
  logic [DC_W-1:0]       r_d_cnt;
  logic [IF_LEN_W-1:0]   r_i_cnt;
  logic [TILE_CNT_W-1:0] r_num_tiles;
  logic [IF_LEN_W-1:0]   r_if_len;
  logic [TILE_CNT_W-1:0] r_load_idx;
  logic [TILE_CNT_W-1:0] r_tile_idx;
  logic                  r_if_last;
  logic                  r_busy;
  logic                  r_done;

  logic w_accept;
  logic w_swap;
  logic w_more;

  // A zero-tile job raises done with busy low; blocking start during that pulse
  // keeps done from ever being high two cycles in a row.
  assign w_accept = start && !r_busy && !r_done;
  assign w_swap   = (r_w_state == W_READY) && (r_if_state == IF_IDLE);
  assign w_more   = (r_load_idx != (r_num_tiles - TILE_CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_state   <= W_IDLE;
      r_if_state  <= IF_IDLE;
      r_w_cnt     <= '0;
      r_d_cnt     <= '0;
      r_i_cnt     <= '0;
      r_num_tiles <= '0;
      r_if_len    <= '0;
      r_load_idx  <= '0;
      r_tile_idx  <= '0;
      r_if_last   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_done) r_busy <= 1'b0;

      case (r_w_state)
        W_IDLE: begin
          if (w_accept) begin
            r_num_tiles <= num_tiles;
            r_if_len    <= if_len;
            r_load_idx  <= '0;
            if (num_tiles == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy    <= 1'b1;
              r_w_state <= W_CLR;
            end
          end
        end
        W_CLR: begin
          r_w_cnt   <= '0;
          r_w_state <= W_LOAD;
        end
        W_LOAD: begin
          if (!stall) begin
            if (r_w_cnt == WC_W'(ARRAY_DIM - 1)) r_w_state <= W_READY;
            else                                 r_w_cnt   <= r_w_cnt + WC_W'(1);
          end
        end
        W_READY: begin
          if (w_swap) begin
            r_tile_idx <= r_load_idx;
            r_if_last  <= !w_more;
            if (w_more) begin
              r_load_idx <= r_load_idx + TILE_CNT_W'(1);
              r_w_state  <= W_CLR;
            end else begin
              r_w_state  <= W_IDLE;
            end
          end
        end
        default: r_w_state <= W_IDLE;
      endcase

      case (r_if_state)
        IF_IDLE: begin
          if (w_swap) begin
            r_i_cnt <= '0;
            r_d_cnt <= '0;
            r_if_state <= (r_if_len == '0) ? IF_DRAIN : IF_RUN;
          end
        end
        IF_RUN: begin
          if (!stall) begin
            if (r_i_cnt == (r_if_len - IF_LEN_W'(1))) begin
              r_d_cnt    <= '0;
              r_if_state <= IF_DRAIN;
            end else begin
              r_i_cnt <= r_i_cnt + IF_LEN_W'(1);
            end
          end
        end
        IF_DRAIN: begin
          // Drain ignores stall: the array keeps shifting partial sums out.
          if (r_d_cnt == DC_W'(DRAIN - 1)) begin
            r_if_state <= IF_IDLE;
            if (r_if_last) r_done <= 1'b1;
          end else begin
            r_d_cnt <= r_d_cnt + DC_W'(1);
          end
        end
        default: r_if_state <= IF_IDLE;
      endcase
    end
  end

  assign w_read   = (r_w_state == W_LOAD) && !stall;
  assign if_read  = (r_if_state == IF_RUN) && !stall;
  assign clr_w    = (r_w_state == W_CLR);
  assign switch   = w_swap;
  assign clr_if   = w_swap;
  assign tile_idx = r_tile_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_tile_seq_controller.sv
// Cycle-accurate scoreboard bench for tile_seq_controller (ARRAY_DIM=4).
// Per-cycle expected output vectors are queued at job start and popped as the DUT runs.
module tb_tile_seq_controller;
  localparam int AD = 4;
  localparam int TW = 8;
  localparam int LW = 16;
  localparam int B_BUSY = 6, B_DONE = 5, B_SW = 4, B_CIF = 3, B_CW = 2, B_WR = 1, B_IR = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] num_tiles;
  logic [LW-1:0] if_len;
  logic          stall;
  logic          w_read, if_read, clr_w, clr_if, switch, busy, done;
  logic [TW-1:0] tile_idx;

  tile_seq_controller #(.ARRAY_DIM(AD), .TILE_CNT_W(TW), .IF_LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .if_len(if_len),
    .stall(stall), .w_read(w_read), .if_read(if_read), .clr_w(clr_w), .clr_if(clr_if),
    .switch(switch), .tile_idx(tile_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [6:0] exp_q [$];
  logic [6:0] exp_tab [64];
  logic [6:0] obs_vec;
  assign obs_vec = {busy, done, switch, clr_if, clr_w, w_read, if_read};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tab();
    for (int i = 0; i < 64; i++) exp_tab[i] = '0;
  endtask

  task automatic setb(input int b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_tab[i][b] = 1'b1;
  endtask

  task automatic tab_case1();
    clr_tab();
    setb(B_CW, 1, 1);  setb(B_WR, 2, 5);
    setb(B_SW, 6, 6);  setb(B_CIF, 6, 6);
    setb(B_IR, 7, 12); setb(B_DONE, 20, 20); setb(B_BUSY, 1, 20);
  endtask

  task automatic tab_case2();
    clr_tab();
    setb(B_CW, 1, 1);   setb(B_WR, 2, 5);   setb(B_SW, 6, 6);   setb(B_CIF, 6, 6);
    setb(B_IR, 7, 12);  setb(B_CW, 7, 7);   setb(B_WR, 8, 11);
    setb(B_SW, 20, 20); setb(B_CIF, 20, 20); setb(B_IR, 21, 26);
    setb(B_DONE, 34, 34); setb(B_BUSY, 1, 34);
  endtask

  // rs_c: cycle of an extra start (num_tiles=3) to be ignored; tc/tv: tile_idx check;
  // abort_c: stop after sampling that cycle (-1 = run all).
  task automatic run_job(input string nm, input int nt, input int il, input logic [63:0] stall_m,
                         input int ncyc, input int rs_c, input int tc, input int tv, input int abort_c);
    for (int c = 0; c < ncyc; c++) exp_q.push_back(exp_tab[c]);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      start     = (c == 0) || (c == rs_c);
      num_tiles = (c == rs_c) ? TW'(3) : TW'(nt);
      if_len    = (c == rs_c) ? LW'(2) : LW'(il);
      stall     = stall_m[c];
      @(negedge clk);
      chk($sformatf("%s c%0d vec", nm, c), 32'(obs_vec), 32'(exp_q.pop_front()));
      if (c == tc) chk($sformatf("%s c%0d tile_idx", nm, c), 32'(tile_idx), 32'(tv));
      if (c == abort_c) break;
    end
    start = 1'b0;
    stall = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] sm;
    rst = 1'b1; start = 1'b0; stall = 1'b0; num_tiles = '0; if_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset vec", 32'(obs_vec), 32'd0);
    chk("reset tile_idx", 32'(tile_idx), 32'd0);
    rst = 1'b0;

    tab_case1();
    run_job("T1", 1, 6, 64'd0, 24, -1, 7, 0, -1);

    tab_case2();
    run_job("T2", 2, 6, 64'd0, 38, -1, 21, 1, -1);

    // Stall in c8 lands on the switch cycle, which stall does not hold.
    clr_tab();
    setb(B_CW, 1, 1);  setb(B_WR, 2, 2); setb(B_WR, 5, 7);
    setb(B_SW, 8, 8);  setb(B_CIF, 8, 8); setb(B_IR, 9, 14);
    setb(B_DONE, 22, 22); setb(B_BUSY, 1, 22);
    sm = '0; sm[3] = 1'b1; sm[4] = 1'b1; sm[8] = 1'b1;
    run_job("T3", 1, 6, sm, 26, -1, 9, 0, -1);

    clr_tab();
    setb(B_DONE, 1, 1);
    run_job("T4a", 0, 6, 64'd0, 4, -1, -1, 0, -1);

    clr_tab();
    setb(B_CW, 1, 1); setb(B_WR, 2, 5); setb(B_SW, 6, 6); setb(B_CIF, 6, 6);
    setb(B_DONE, 14, 14); setb(B_BUSY, 1, 14);
    run_job("T4b", 1, 0, 64'd0, 18, -1, -1, 0, -1);

    tab_case2();
    run_job("T5a", 2, 6, 64'd0, 38, -1, -1, 0, 9);
    #2 rst = 1'b1;
    #1;
    chk("T5 rst vec", 32'(obs_vec), 32'd0);
    chk("T5 rst tile_idx", 32'(tile_idx), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tab_case1();
    run_job("T5b", 1, 6, 64'd0, 24, -1, 7, 0, -1);

    tab_case1();
    run_job("T6", 1, 6, 64'd0, 24, 5, 21, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
